inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- Instruction fetch unit and initiator side of the instruction-memory interface.
- Drives the word address to the combinational instruction ROM and captures the returned 32-bit instruction into an instruction register (IR) for decode.
- Handles decode back-pressure, taken-branch skips (BEQ/BNE "skip next"), register jumps (JMP) and a halt/resume control.
- Sits between the instruction ROM and the decode/execute stage.

Parameters:
- ResetPc, 32'd0, PC value loaded on reset and on resume-from-halt-with-restart.
- InstAddrBus, 32, width of the PC and address bus.
- InstBusWidth, 32, width of the instruction bus.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- address  output  32  word address to the instruction ROM. Combinational, always equal to the PC register.
- inst  input  32  instruction word returned by the ROM. Valid in the same cycle as address.
- stall  input  1  decode not ready. Hold the IR and PC.
- skip  input  1  branch taken for the instruction in the IR. Discard the next sequential instruction.
- jump  input  1  JMP executing for the instruction in the IR. Redirect the PC.
- jumpTarget  input  32  new PC, sampled when jump=1.
- halt  input  1  enter the HALT state.
- resume  input  1  leave HALT.
- restart  input  1  qualifier for resume: 1 reloads ResetPc, 0 keeps the PC.
- ir  output  32  registered instruction to decode.
- irValid  output  1  ir holds a real instruction. When 0, ir is NOP (32'd0).
- irPc  output  32  address from which ir was fetched.
- halted  output  1  high while in the HALT state.

Behaviour:
- Reset: synchronous, checked first every edge.
  - PC<=ResetPc, ir<=0, irValid<=0, irPc<=0, halted<=0, state<=START.
- States: START, RUN, HALT.
- START
  - Exactly one cycle; ROM address settles to ResetPc.
  - ir and irValid stay at their reset values.
  - Next state RUN unconditionally, including when halt=1. halt is honoured from RUN onward.
- RUN: per-edge priority is jump > skip > halt > stall > normal.
  - jump=1:
    - PC<=jumpTarget, ir<=0, irValid<=0, irPc unchanged.
    - Exactly one bubble. The instruction at the old PC is never issued.
    - Applies even when stall=1.
  - skip=1:
    - PC<=PC+1, ir<=0, irValid<=0.
    - The word at the old PC (irPc+1) is dropped. Next issued word is irPc+2.
    - Applies even when stall=1.
  - jump and skip both 1: jump wins, skip ignored.
  - halt=1:
    - state<=HALT, halted<=1, ir<=0, irValid<=0.
    - PC unchanged; the word at PC is re-fetched after resume.
  - stall=1 (no redirect, no halt): PC, ir, irValid, irPc all hold.
  - Normal: ir<=inst, irPc<=PC, irValid<=1, PC<=PC+1.
- HALT
  - PC frozen, irValid=0, ir=0. stall, skip and jump are ignored.
  - resume=1: state<=RUN, halted<=0.
    - If restart=1, PC<=ResetPc.
    - First instruction issues on the following edge.
  - halt and resume both 1 in HALT: resume wins.
- Latency:
  - Address to ir is 1 cycle.
  - The first valid instruction after reset appears 2 edges after rst deasserts: START edge, then first capture.
- Arithmetic:
  - PC+1 is modulo 2^32; 32'hFFFFFFFF wraps to 0 with no flag.
  - jumpTarget is used unmodified, with no alignment.
- Decode depends on the IR: when irValid=0, ir is guaranteed all-zero (opcode 0, NOP).
- Redirect inputs (jump, skip) are only meaningful while irValid=1. The block does not check this; the bench must not drive them otherwise.

Test Plan:
- Reset then free-run, ROM word n = n+100, no stall:
  - irValid=0 for START and the first capture edge.
  - Then irPc=0,1,2,3 with ir=100,101,102,103 on consecutive cycles.
  - address always equals PC.
- stall=1 for 3 cycles while irPc=2:
  - ir=102, irPc=2 and address=3 held for 3 cycles.
  - After release, irPc=3 is next, with no duplicate or missing word.
- skip=1 for one cycle while irPc=5:
  - Next cycle irValid=0 and ir=0.
  - Following cycle irPc=7. Word 6 is never issued.
- jump=1 with jumpTarget=4 and skip=1 together, while irPc=9 and stall=1:
  - One bubble, then irPc=4, 5, ...
  - Word 10 is never issued.
- halt=1 while PC=12 then resume=1 with restart=0 after 4 cycles:
  - halted=1 and irValid=0 throughout HALT.
  - Next issued irPc=12.
  - Repeat with restart=1: next issued irPc=ResetPc=0.
- Wrap and mid-run reset:
  - jumpTarget=32'hFFFFFFFF, then issued irPc sequence is FFFFFFFF, 0, 1.
  - Assert rst mid-run with stall=1: all outputs return to reset values on that edge and the START sequence repeats.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Instruction-fetch bundle: ROM address/data, decode handshake and the IR
// issued to decode. The master side is the fetch unit.
interface inst_fetch_if #(
    parameter int unsigned InstAddrBus  = 32,
    parameter int unsigned InstBusWidth = 32
);
    logic [InstAddrBus-1:0]  address;
    logic [InstBusWidth-1:0] inst;
    logic                    stall;
    logic                    skip;
    logic                    jump;
    logic [InstAddrBus-1:0]  jumpTarget;
    logic                    halt;
    logic                    resume;
    logic                    restart;
    logic [InstBusWidth-1:0] ir;
    logic                    irValid;
    logic [InstAddrBus-1:0]  irPc;
    logic                    halted;

    modport master (
        output address, ir, irValid, irPc, halted,
        input  inst, stall, skip, jump, jumpTarget, halt, resume, restart
    );

    modport slave (
        input  address, ir, irValid, irPc, halted,
        output inst, stall, skip, jump, jumpTarget, halt, resume, restart
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: drives the PC to a combinational ROM, captures the word
// into the IR, and handles stall, skip-next, jump and halt/resume.
module inst_fetch #(
    parameter int unsigned          InstAddrBus  = 32,
    parameter int unsigned          InstBusWidth = 32,
    parameter logic [InstAddrBus-1:0] ResetPc    = '0
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  bus
);

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [InstAddrBus-1:0]  pc_q, pc_d;
    logic [InstBusWidth-1:0] ir_q, ir_d;
    logic                    ir_valid_q, ir_valid_d;
    logic [InstAddrBus-1:0]  ir_pc_q, ir_pc_d;
    logic                    halted_q, halted_d;

    function automatic logic [InstAddrBus-1:0] next_pc(input logic [InstAddrBus-1:0] pc);
        return pc + InstAddrBus'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        ir_pc_d    = ir_pc_q;
        halted_d   = halted_q;

        unique case (state_q)
            START: begin
                // One settling cycle for the ROM at ResetPc; halt is not honoured yet.
                state_d = RUN;
            end
            RUN: begin
                if (bus.jump) begin
                    pc_d       = bus.jumpTarget;
                    ir_d       = '0;
                    ir_valid_d = 1'b0;
                end else if (bus.skip) begin
                    // PC already points one past the IR; stepping it drops that word.
                    pc_d       = next_pc(pc_q);
                    ir_d       = '0;
                    ir_valid_d = 1'b0;
                end else if (bus.halt) begin
                    state_d    = HALT;
                    halted_d   = 1'b1;
                    ir_d       = '0;
                    ir_valid_d = 1'b0;
                end else if (!bus.stall) begin
                    ir_d       = bus.inst;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    pc_d       = next_pc(pc_q);
                end
            end
            HALT: begin
                ir_d       = '0;
                ir_valid_d = 1'b0;
                if (bus.resume) begin
                    state_d  = RUN;
                    halted_d = 1'b0;
                    if (bus.restart) begin
                        pc_d = ResetPc;
                    end
                end
            end
            default: begin
                state_d = START;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= START;
            pc_q       <= ResetPc;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            ir_pc_q    <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            ir_pc_q    <= ir_pc_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.address = pc_q;
    assign bus.ir      = ir_q;
    assign bus.irValid = ir_valid_q;
    assign bus.irPc    = ir_pc_q;
    assign bus.halted  = halted_q;

endmodule
